// File: rtl/mac_accum_if.sv
// Operand stream and frame-result bundle between the MAC feeder and the accumulate core.
interface mac_accum_if #(
  parameter int unsigned N     = 16,
  parameter int unsigned CNT_W = 8
);
  logic                 a_valid;
  logic                 a_ready;
  logic [N-1:0]         a;
  logic [N-1:0]         b;
  logic                 a_last;
  logic [2*N-1:0]       qacc;
  logic                 qsload;
  logic                 sum_err;
  logic                 mult_err;
  logic                 len_err;
  logic [CNT_W-1:0]     term_cnt;
  logic                 busy;

  modport master (
    output a_valid, a, b, a_last,
    input  a_ready, qacc, qsload, sum_err, mult_err, len_err, term_cnt, busy
  );

  modport slave (
    input  a_valid, a, b, a_last,
    output a_ready, qacc, qsload, sum_err, mult_err, len_err, term_cnt, busy
  );
endinterface

// File: rtl/mac_accum.sv
// Two-stage signed multiply-accumulate core: registered product, then wrapping 2N-bit accumulate.
// Frames close on a_last or at MAX_LEN terms and end with a one-cycle qsload strobe.
module mac_accum #(
  parameter int unsigned N       = 16,
  parameter int unsigned Q       = 8,
  parameter int unsigned MAX_LEN = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  mac_accum_if.slave  bus
);

  localparam int unsigned W = 2 * N;

  // Reject builds where the counter cannot reach MAX_LEN or Q leaves no integer bits.
  if ((2 ** CNT_W) <= MAX_LEN || Q >= N) begin : gen_param_check
    $error("mac_accum: invalid parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_e;

  state_e             state_q;
  logic [W-1:0]       prod_q;
  logic               prod_v_q;
  logic               first_q;
  logic [W-1:0]       acc_q;
  logic [CNT_W-1:0]   term_cnt_q;
  logic               qsload_q;
  logic               sum_err_q;
  logic               mult_err_q;
  logic               len_err_q;

  logic               ready;
  logic               accept;
  logic               frame_end;
  logic               len_hit;
  logic [CNT_W-1:0]   cnt_next;
  logic signed [W-1:0] a_ext;
  logic signed [W-1:0] b_ext;
  logic signed [W-1:0] prod_d;
  logic [W-1:0]       sum;
  logic               sum_ovf;
  logic               prod_guard;

  always_comb begin
    ready      = (state_q == StIdle) || (state_q == StAcc);
    accept     = bus.a_valid && ready;
    cnt_next   = (state_q == StIdle) ? CNT_W'(1) : term_cnt_q + CNT_W'(1);
    len_hit    = (cnt_next == CNT_W'(MAX_LEN));
    frame_end  = bus.a_last || len_hit;
    a_ext      = {{N{bus.a[N-1]}}, bus.a};
    b_ext      = {{N{bus.b[N-1]}}, bus.b};
    prod_d     = a_ext * b_ext;
    sum        = acc_q + prod_q;
    // Overflow only when both addends share a sign and the result flips it.
    sum_ovf    = (prod_q[W-1] == acc_q[W-1]) && (sum[W-1] != prod_q[W-1]);
    prod_guard = (prod_q[W-1] != prod_q[W-2]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      prod_q     <= '0;
      prod_v_q   <= 1'b0;
      first_q    <= 1'b0;
      acc_q      <= '0;
      term_cnt_q <= '0;
      qsload_q   <= 1'b0;
      sum_err_q  <= 1'b0;
      mult_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else if (clr) begin
      state_q    <= StIdle;
      prod_v_q   <= 1'b0;
      first_q    <= 1'b0;
      acc_q      <= '0;
      term_cnt_q <= '0;
      qsload_q   <= 1'b0;
      sum_err_q  <= 1'b0;
      mult_err_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      qsload_q <= 1'b0;
      prod_v_q <= accept;

      if (accept) begin
        prod_q     <= prod_d;
        first_q    <= (state_q == StIdle);
        term_cnt_q <= cnt_next;
        if (state_q == StIdle) begin
          sum_err_q  <= 1'b0;
          mult_err_q <= 1'b0;
          len_err_q  <= 1'b0;
        end
        if (frame_end) begin
          state_q <= StDrain;
          if (!bus.a_last) len_err_q <= 1'b1;
        end else begin
          state_q <= StAcc;
        end
      end else begin
        case (state_q)
          StDrain: begin
            state_q  <= StDone;
            qsload_q <= 1'b1;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= state_q;
        endcase
      end

      // Stage 2: the first term of a frame loads rather than accumulates.
      if (prod_v_q) begin
        if (first_q) begin
          acc_q <= prod_q;
        end else begin
          acc_q <= sum;
          if (sum_ovf) sum_err_q <= 1'b1;
        end
        if (prod_guard) mult_err_q <= 1'b1;
      end
    end
  end

  assign bus.a_ready  = ready;
  assign bus.qacc     = acc_q;
  assign bus.qsload   = qsload_q;
  assign bus.sum_err  = sum_err_q;
  assign bus.mult_err = mult_err_q;
  assign bus.len_err  = len_err_q;
  assign bus.term_cnt = term_cnt_q;
  assign bus.busy     = (state_q != StIdle);

endmodule
